// File: rtl/fetch_prefetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_prefetch_unit_pkg                                                    |
// | Shared widths and pc_src encodings for the instruction-fetch front end.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_prefetch_unit_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_ALU    = 2'b10,
        PC_SRC_RSVD   = 2'b11
    } pc_src_e;

    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PC_SRC_BRANCH) || (src == PC_SRC_ALU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue                                                                |
// | In-order circular buffer of {pc, instr, filled} with alloc/fill/pop/flush. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_alloc,
    input  logic [WORD-1:0]            i_alloc_pc,
    input  logic                       i_fill,
    input  logic [INSTR_LEN-1:0]       i_fill_data,
    input  logic                       i_pop,
    output logic                       o_head_filled,
    output logic [WORD-1:0]            o_head_pc,
    output logic [INSTR_LEN-1:0]       o_head_instr,
    output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
    output logic [$clog2(DEPTH+1)-1:0] o_unfilled
);
    import fetch_prefetch_unit_pkg::*;

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_ptr_w-1:0]   r_fill;
    logic [c_cnt_w-1:0]   r_occ;
    logic [c_cnt_w-1:0]   r_unf;
    logic [WORD-1:0]      r_pc     [DEPTH];
    logic [INSTR_LEN-1:0] r_instr  [DEPTH];
    logic                 r_filled [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            r_occ  <= '0;
            r_unf  <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            r_occ  <= '0;
            r_unf  <= '0;
        end else begin
            if (i_alloc) r_tail <= r_tail + 1'b1;
            if (i_fill)  r_fill <= r_fill + 1'b1;
            if (i_pop)   r_head <= r_head + 1'b1;
            r_occ <= r_occ + c_cnt_w'(i_alloc) - c_cnt_w'(i_pop);
            r_unf <= r_unf + c_cnt_w'(i_alloc) - c_cnt_w'(i_fill);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_alloc_hit;
            logic w_fill_hit;
            logic w_pop_hit;

            assign w_alloc_hit = i_alloc && (r_tail == c_ptr_w'(gi));
            assign w_fill_hit  = i_fill  && (r_fill == c_ptr_w'(gi));
            assign w_pop_hit   = i_pop   && (r_head == c_ptr_w'(gi));

            // A popped slot must drop its filled bit, or an empty queue would
            // present stale data once head wraps back onto it.
            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pc[gi]     <= '0;
                    r_instr[gi]  <= '0;
                    r_filled[gi] <= 1'b0;
                end else if (i_flush) begin
                    r_filled[gi] <= 1'b0;
                end else begin
                    if (w_alloc_hit) begin
                        r_pc[gi]     <= i_alloc_pc;
                        r_filled[gi] <= 1'b0;
                    end
                    if (w_pop_hit) r_filled[gi] <= 1'b0;
                    if (w_fill_hit) begin
                        r_instr[gi]  <= i_fill_data;
                        r_filled[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign o_head_filled = r_filled[r_head];
    assign o_head_pc     = r_pc[r_head];
    assign o_head_instr  = r_instr[r_head];
    assign o_occupancy   = r_occ;
    assign o_unfilled    = r_unf;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_prefetch_unit                                                        |
// | Fetch front end: PC sequencing, redirect, stale-response drop, issue gate. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_prefetch_unit #(
    parameter int              WORD      = fetch_prefetch_unit_pkg::WORD,
    parameter int              INSTR_LEN = fetch_prefetch_unit_pkg::INSTR_LEN,
    parameter int              DEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 pc_src,
    input  logic [WORD-1:0]            branch_target,
    input  logic [WORD-1:0]            alu_result,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [WORD-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INSTR_LEN-1:0]       imem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_LEN-1:0]       instruction,
    output logic [WORD-1:0]            pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    import fetch_prefetch_unit_pkg::*;

    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic                 r_active;
    logic [WORD-1:0]      r_fetch_pc;
    logic [c_cnt_w-1:0]   r_drop;

    logic                 w_redirect;
    logic [WORD-1:0]      w_target_raw;
    logic [WORD-1:0]      w_target;
    logic [c_cnt_w-1:0]   w_unfilled;
    logic [c_cnt_w-1:0]   w_occ;
    logic [c_cnt_w:0]     w_inflight;
    logic                 w_issue;
    logic                 w_rsp_drop;
    logic                 w_rsp_fill;
    logic                 w_rsp_err;
    logic                 w_head_filled;
    logic                 w_pop;

    assign w_redirect   = is_redirect(pc_src);
    assign w_target_raw = (pc_src == PC_SRC_ALU) ? alu_result : branch_target;
    assign w_target     = {w_target_raw[WORD-1:2], 2'b00};

    // Requests still owed by memory count against the queue, whether they
    // will land in an entry or be thrown away after a redirect.
    assign w_inflight     = {1'b0, w_unfilled} + {1'b0, r_drop};
    assign imem_req_valid = r_active && !w_redirect
                            && (w_occ < c_cnt_w'(DEPTH))
                            && (w_inflight < (c_cnt_w+1)'(DEPTH));
    assign imem_req_addr  = r_active ? r_fetch_pc : '0;
    assign w_issue        = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
    assign w_rsp_fill = imem_rsp_valid && (r_drop == '0) && (w_unfilled != '0);
    assign w_rsp_err  = imem_rsp_valid && (r_drop == '0) && (w_unfilled == '0);

    assign out_valid = w_head_filled && !w_redirect;
    assign w_pop     = out_valid && out_ready;
    assign occupancy = w_occ;

    fetch_queue #(
        .WORD      (WORD),
        .INSTR_LEN (INSTR_LEN),
        .DEPTH     (DEPTH)
    ) u_fetch_queue (
        .clk           (clk),
        .i_rst_n       (reset_n),
        .i_flush       (w_redirect),
        .i_alloc       (w_issue),
        .i_alloc_pc    (r_fetch_pc),
        .i_fill        (w_rsp_fill),
        .i_fill_data   (imem_rsp_data),
        .i_pop         (w_pop),
        .o_head_filled (w_head_filled),
        .o_head_pc     (pc),
        .o_head_instr  (instruction),
        .o_occupancy   (w_occ),
        .o_unfilled    (w_unfilled)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_drop     <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_drop     <= r_drop + w_unfilled - c_cnt_w'(w_rsp_drop || w_rsp_fill);
            end else begin
                if (w_issue)    r_fetch_pc <= r_fetch_pc + WORD'(4);
                if (w_rsp_drop) r_drop     <= r_drop - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && w_rsp_err) $error("imem response with no outstanding request");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_prefetch_unit                                                     |
// | Randomised and directed bench with a queue-based reference model.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pc_src;
    logic [63:0] branch_target;
    logic [63:0] alu_result;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .alu_result     (alu_result),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc             (pc),
        .occupancy      (occupancy)
    );

    typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;

    ent_t        q[$];
    mreq_t       mq[$];
    logic [63:0] m_fetch_pc;
    int          m_drop;
    bit          m_active;
    int          cyc;
    int          lat;
    int          n_vec;
    int          n_fail;
    logic [63:0] req_log[$];
    logic [63:0] pop_pc_log[$];
    logic [31:0] pop_ins_log[$];
    int          pop_cyc_log[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] at64(input logic [63:0] qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return 'x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mq.delete();
        m_fetch_pc = 64'h0;
        m_drop     = 0;
        m_active   = 1'b0;
    endtask

    function automatic bit mem_ready_now();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    function automatic void clear_logs();
        req_log.delete();
        pop_pc_log.delete();
        pop_ins_log.delete();
        pop_cyc_log.delete();
    endfunction

    // One clock: present memory response, check outputs, then advance the model.
    task automatic do_cycle();
        bit          redirect, e_req, e_ov, rsp, pop, hs, done;
        int          unf;
        logic [63:0] tgt;
        rsp = reset_n && mem_ready_now();
        imem_rsp_valid = rsp;
        if (rsp) imem_rsp_data = mem_word(mq[0].addr);
        else     imem_rsp_data = 32'($urandom);
        #1;
        redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
        unf = 0;
        foreach (q[i]) if (!q[i].filled) unf++;
        e_req = reset_n && m_active && !redirect && (q.size() < DEPTH) && ((unf + m_drop) < DEPTH);
        e_ov  = reset_n && !redirect && (q.size() > 0) && q[0].filled;
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("req_valid", 64'(imem_req_valid), 64'(e_req));
        if (e_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        if (e_ov) begin
            chk("out_pc", pc, q[0].pc);
            chk("out_instr", 64'(instruction), 64'(q[0].instr));
        end
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (out_valid && out_ready) begin
            pop_pc_log.push_back(pc);
            pop_ins_log.push_back(instruction);
            pop_cyc_log.push_back(cyc);
        end
        pop = e_ov && out_ready;
        hs  = e_req && imem_req_ready;
        tgt = (pc_src == 2'b10) ? alu_result : branch_target;
        @(posedge clk);
        if (reset_n) begin
            if (rsp) mq.delete(0);
            if (redirect) begin
                m_drop = m_drop + unf - ((rsp && (m_drop > 0 || unf > 0)) ? 1 : 0);
                q.delete();
                m_fetch_pc = {tgt[63:2], 2'b00};
            end else begin
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        done = 1'b0;
                        foreach (q[i]) begin
                            if (!done && !q[i].filled) begin
                                q[i].instr  = imem_rsp_data;
                                q[i].filled = 1'b1;
                                done = 1'b1;
                            end
                        end
                    end
                end
                if (pop) q.delete(0);
                if (hs) begin
                    q.push_back('{m_fetch_pc, 32'h0, 1'b0});
                    mq.push_back('{m_fetch_pc, cyc + lat});
                    m_fetch_pc = m_fetch_pc + 64'd4;
                end
            end
            m_active = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        pc_src = 2'b00;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        do_cycle();
        do_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        int r;
        n_vec = 0; n_fail = 0; cyc = 0; lat = 1;
        reset_n = 1'b0; pc_src = 2'b00; branch_target = '0; alu_result = '0;
        imem_req_ready = 1'b0; out_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);

        // Sequential stream, 1-cycle memory, decode always ready.
        do_reset(); lat = 1; clear_logs();
        repeat (12) do_cycle();
        for (int i = 0; i < 4; i++) begin
            chk("A_req_addr", at64(req_log, i), 64'(4 * i));
            chk("A_pop_pc", at64(pop_pc_log, i), 64'(4 * i));
        end
        chk("A_pop_instr0", (pop_ins_log.size() > 0) ? 64'(pop_ins_log[0]) : 'x, 64'(mem_word(64'h0)));
        chk("A_pop_spacing", (pop_cyc_log.size() > 3) ? 64'(pop_cyc_log[3] - pop_cyc_log[0]) : 'x, 64'd3);

        // Decode stalled: exactly DEPTH requests, then one more after a pop.
        do_reset(); lat = 1; out_ready = 1'b0; clear_logs();
        repeat (10) do_cycle();
        chk("B_occ_full", 64'(occupancy), 64'd4);
        chk("B_req_count", 64'(req_log.size()), 64'd4);
        chk("B_req_valid_full", 64'(imem_req_valid), 64'd0);
        out_ready = 1'b1;
        do_cycle();
        out_ready = 1'b0;
        chk("B_req_after_pop", 64'(imem_req_valid), 64'd1);
        repeat (3) do_cycle();
        chk("B_req_count2", 64'(req_log.size()), 64'd5);
        chk("B_occ_full2", 64'(occupancy), 64'd4);

        // Branch with three requests outstanding on a 3-cycle memory.
        do_reset(); lat = 3; out_ready = 1'b0; clear_logs();
        budget = 0;
        while (req_log.size() < 3 && budget < 30) begin do_cycle(); budget++; end
        chk("C_three_issued", 64'(req_log.size()), 64'd3);
        imem_req_ready = 1'b0;
        pc_src = 2'b01; branch_target = 64'h103;
        do_cycle();
        pc_src = 2'b00; imem_req_ready = 1'b1; out_ready = 1'b1; clear_logs();
        repeat (20) do_cycle();
        chk("C_req_after_branch", at64(req_log, 0), 64'h100);
        chk("C_first_pop_pc", at64(pop_pc_log, 0), 64'h100);
        chk("C_first_pop_instr", (pop_ins_log.size() > 0) ? 64'(pop_ins_log[0]) : 'x, 64'(mem_word(64'h100)));

        // ALU redirect coinciding with a response and out_ready=1.
        do_reset(); lat = 2; out_ready = 1'b1;
        repeat (6) do_cycle();
        budget = 0;
        while (!mem_ready_now() && budget < 20) begin do_cycle(); budget++; end
        pc_src = 2'b10; alu_result = 64'h40; branch_target = 64'h1234;
        #1;
        chk("D_out_valid_redirect", 64'(out_valid), 64'd0);
        chk("D_req_valid_redirect", 64'(imem_req_valid), 64'd0);
        do_cycle();
        pc_src = 2'b00;
        chk("D_occ_after", 64'(occupancy), 64'd0);
        clear_logs();
        repeat (10) do_cycle();
        chk("D_req_after_alu", at64(req_log, 0), 64'h40);
        chk("D_first_pop_pc", at64(pop_pc_log, 0), 64'h40);

        // Address wrap through 2^64, reserved pc_src acting sequential.
        pc_src = 2'b01; branch_target = 64'hFFFF_FFFF_FFFF_FFFB;
        do_cycle();
        pc_src = 2'b11; clear_logs();
        repeat (12) do_cycle();
        chk("E_req0", at64(req_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("E_req1", at64(req_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("E_req2", at64(req_log, 2), 64'h0);
        chk("E_pop0", at64(pop_pc_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("E_pop2", at64(pop_pc_log, 2), 64'h0);

        // Asynchronous reset between edges, mid-stream.
        pc_src = 2'b00;
        repeat (5) do_cycle();
        #2;
        reset_n = 1'b0;
        imem_rsp_valid = 1'b0;
        model_reset();
        #1;
        chk("F_req_valid", 64'(imem_req_valid), 64'd0);
        chk("F_req_addr", imem_req_addr, 64'd0);
        chk("F_out_valid", 64'(out_valid), 64'd0);
        chk("F_occupancy", 64'(occupancy), 64'd0);
        chk("F_pc", pc, 64'd0);
        do_cycle();
        do_cycle();
        reset_n = 1'b1;
        clear_logs();
        repeat (8) do_cycle();
        chk("F_restart_req", at64(req_log, 0), 64'h0);
        chk("F_restart_pop", at64(pop_pc_log, 0), 64'h0);

        // Randomised traffic at several memory latencies.
        for (int ch = 0; ch < 4; ch++) begin
            do_reset();
            lat = 1 + ch;
            for (int k = 0; k < 500; k++) begin
                r = $urandom_range(0, 99);
                pc_src = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r < 12) ? 2'b11 : 2'b00;
                branch_target = {$urandom, $urandom};
                alu_result    = {$urandom, $urandom};
                out_ready      = ($urandom_range(0, 99) < 70);
                imem_req_ready = ($urandom_range(0, 99) < 75);
                do_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
